// File: rtl/video_timing_pkg.sv
// Shared types and the built-in mode table for the video timing generator.
// Each table entry describes one raster: horizontal and vertical totals, sync, back porch, active size and sync polarity.
package video_timing_pkg;

    localparam int TIM_W      = 12;
    localparam int MODE_W     = 2;
    localparam int TABLE_SIZE = 4;

    typedef logic [MODE_W-1:0] mode_idx_t;

    // A polarity bit of 1 means the sync is active high.
    typedef struct packed {
        logic [TIM_W-1:0] h_total;
        logic [TIM_W-1:0] h_sync;
        logic [TIM_W-1:0] h_bporch;
        logic [TIM_W-1:0] h_res;
        logic [TIM_W-1:0] v_total;
        logic [TIM_W-1:0] v_sync;
        logic [TIM_W-1:0] v_bporch;
        logic [TIM_W-1:0] v_res;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t MODE_TABLE [TABLE_SIZE] = '{
        '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0},
        '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1},
        '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0},
        '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1}
    };

    function automatic mode_idx_t clamp_mode(input mode_idx_t req, input int num_modes,
                                             input int dflt);
        if (int'(req) >= num_modes) return mode_idx_t'(dflt);
        return req;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle of the generator's raster outputs, shared by the core and its consumers.
interface video_timing_gen_if #(parameter int CNT_W = 12);
    import video_timing_pkg::*;

    // de qualifies x; there is no backpressure, the raster always advances one pixel per clock.
    mode_idx_t        mode;
    logic             hs;
    logic             vs;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             sof;
    logic             eol;

    modport master (output mode, hs, vs, de, x, y, sof, eol);
    modport slave  (input  mode, hs, vs, de, x, y, sof, eol);

endinterface

// File: rtl/video_timing_gen_core.sv
// Horizontal/vertical raster counters, sync/DE decode and registered outputs.
// The mode in effect only changes at a frame boundary or while the generator is disabled.
module video_timing_gen_core
    import video_timing_pkg::*;
#(
    parameter int CNT_W        = 12,
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 3
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      en_i,
    input  mode_idx_t mode_req_i,
    input  timing_t   tim_i,
    video_timing_gen_if.master vid
);

    localparam mode_idx_t        DFLT_MODE = mode_idx_t'(DEFAULT_MODE);
    localparam timing_t          DFLT_TIM  = MODE_TABLE[DEFAULT_MODE];
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    mode_idx_t        mode_pend_q, mode_act_q, mode_act_d;

    logic [CNT_W-1:0] h_total, h_sync, h_start, h_end, h_res;
    logic [CNT_W-1:0] v_total, v_sync, v_start, v_end;
    logic [CNT_W-1:0] x_raw, y_raw;
    logic             hs_raw, vs_raw, h_act, v_act, de_raw;

    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d, eol_q, eol_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        h_total = CNT_W'(tim_i.h_total);
        h_sync  = CNT_W'(tim_i.h_sync);
        h_res   = CNT_W'(tim_i.h_res);
        h_start = h_sync + CNT_W'(tim_i.h_bporch);
        h_end   = h_start + h_res;
        v_total = CNT_W'(tim_i.v_total);
        v_sync  = CNT_W'(tim_i.v_sync);
        v_start = v_sync + CNT_W'(tim_i.v_bporch);
        v_end   = v_start + CNT_W'(tim_i.v_res);

        hs_raw = h_cnt_q < h_sync;
        vs_raw = v_cnt_q < v_sync;
        h_act  = (h_cnt_q >= h_start) && (h_cnt_q < h_end);
        v_act  = (v_cnt_q >= v_start) && (v_cnt_q < v_end);
        de_raw = en_i && h_act && v_act;
        x_raw  = h_cnt_q - h_start;
        y_raw  = v_cnt_q - v_start;

        // Disabling parks the raster at the origin and lets a pending mode in at once.
        mode_act_d = mode_act_q;
        h_cnt_d    = h_cnt_q + CNT_ONE;
        v_cnt_d    = v_cnt_q;
        if (!en_i) begin
            h_cnt_d    = '0;
            v_cnt_d    = '0;
            mode_act_d = mode_pend_q;
        end else if (h_cnt_q == h_total - CNT_ONE) begin
            h_cnt_d = '0;
            if (v_cnt_q == v_total - CNT_ONE) begin
                v_cnt_d    = '0;
                mode_act_d = mode_pend_q;
            end else begin
                v_cnt_d = v_cnt_q + CNT_ONE;
            end
        end

        hs_d  = en_i ? (hs_raw ~^ tim_i.hs_pol) : ~tim_i.hs_pol;
        vs_d  = en_i ? (vs_raw ~^ tim_i.vs_pol) : ~tim_i.vs_pol;
        de_d  = de_raw;
        x_d   = de_raw ? x_raw : '0;
        y_d   = (en_i && v_act) ? y_raw : '0;
        sof_d = de_raw && (x_raw == '0) && (y_raw == '0);
        eol_d = de_raw && (x_raw == h_res - CNT_ONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            mode_pend_q <= DFLT_MODE;
            mode_act_q  <= DFLT_MODE;
            hs_q        <= ~DFLT_TIM.hs_pol;
            vs_q        <= ~DFLT_TIM.vs_pol;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_pend_q <= clamp_mode(mode_req_i, NUM_MODES, DEFAULT_MODE);
            mode_act_q  <= mode_act_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
        end
    end

    assign vid.mode = mode_act_q;
    assign vid.hs   = hs_q;
    assign vid.vs   = vs_q;
    assign vid.de   = de_q;
    assign vid.x    = x_q;
    assign vid.y    = y_q;
    assign vid.sof  = sof_q;
    assign vid.eol  = eol_q;

endmodule

// File: rtl/video_timing_rom.sv
// Combinational lookup from mode index to timing record.
// Kept separate so the table can be swapped without touching the counter logic.
module video_timing_rom
    import video_timing_pkg::*;
(
    input  mode_idx_t mode_i,
    output timing_t   tim_o
);

    always_comb tim_o = MODE_TABLE[mode_i];

endmodule

// File: rtl/video_timing_gen.sv
// Top of the table-driven video timing generator: mode ROM plus raster core,
// flattened onto the pixel-clock port list used by the DVI TX and frame-buffer paths.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W        = 12,
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 3
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    input  logic             I_en,
    input  mode_idx_t        I_mode,
    output mode_idx_t        O_mode,
    output logic             O_hs,
    output logic             O_vs,
    output logic             O_de,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_sof,
    output logic             O_eol
);

    video_timing_gen_if #(.CNT_W(CNT_W)) vid ();
    timing_t tim;

    // The ROM is addressed by the mode in effect, never by the raw request.
    video_timing_rom u_rom (
        .mode_i (vid.mode),
        .tim_o  (tim)
    );

    video_timing_gen_core #(
        .CNT_W        (CNT_W),
        .NUM_MODES    (NUM_MODES),
        .DEFAULT_MODE (DEFAULT_MODE)
    ) u_core (
        .clk_i      (I_pxl_clk),
        .rst_ni     (I_rst_n),
        .en_i       (I_en),
        .mode_req_i (I_mode),
        .tim_i      (tim),
        .vid        (vid)
    );

    assign O_mode = vid.mode;
    assign O_hs   = vid.hs;
    assign O_vs   = vid.vs;
    assign O_de   = vid.de;
    assign O_x    = vid.x;
    assign O_y    = vid.y;
    assign O_sof  = vid.sof;
    assign O_eol  = vid.eol;

endmodule
